// File: rtl/cpu_defs.sv
// Shared core definitions: opcode/funct fields, PC-source mux codes, sequencer states
// and the coarse instruction classes the sequencer branches on.
package cpu_defs;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_EXC    = 2'd3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_BRANCH = 3'd2,
    ST_JUMP   = 3'd3,
    ST_JR     = 3'd4,
    ST_EXEC   = 3'd5,
    ST_EXC    = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_BRANCH,
    CLS_JUMP,
    CLS_JR,
    CLS_EXEC,
    CLS_ILLEGAL
  } iclass_t;
endpackage

// File: rtl/pc_sequencer_opcode_classifier.sv
// Combinational opcode/funct decode into the instruction class that picks the
// sequencer's post-DECODE state.
module opcode_classifier
  import cpu_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass
);
  always_comb begin
    iclass = CLS_ILLEGAL;
    case (opcode)
      OP_BEQ, OP_BNE: iclass = CLS_BRANCH;
      OP_J, OP_JAL:   iclass = CLS_JUMP;
      OP_RTYPE:       iclass = (funct == FN_JR) ? CLS_JR : CLS_EXEC;
      OP_ADDI, OP_SLTI, OP_LUI, OP_LW, OP_SW: iclass = CLS_EXEC;
      default:        iclass = CLS_ILLEGAL;
    endcase
  end
endmodule

// File: rtl/pc_sequencer.sv
// Multicycle-core PC sequencer: walks fetch/decode/branch/jump/exec/exception phases
// and drives the PC-source mux select plus PC/IR/EPC write strobes.
module pc_sequencer
  import cpu_defs::*;
#(
  parameter int FETCH_TIMEOUT = 255,
  parameter int PCSRC_W       = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               mem_ack,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               alu_zero,
  input  logic               alu_ovf,
  input  logic               exec_done,
  output logic               fetch_req,
  output logic               ir_write,
  output logic               pc_write,
  output logic [PCSRC_W-1:0] pc_source,
  output logic               epc_write,
  output logic [2:0]         state_dbg
);
  localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] tmo_q, tmo_d;
  logic [1:0] pc_sel;
  iclass_t    cls;
  logic       br_taken;

  opcode_classifier u_cls (
    .opcode (opcode),
    .funct  (funct),
    .iclass (cls)
  );

  assign br_taken  = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = '0;
    fetch_req = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    epc_write = 1'b0;
    pc_sel    = PCSRC_ALU;
    case (state_q)
      ST_FETCH: begin
        fetch_req = 1'b1;
        // ack beats a timeout landing in the same cycle
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_EXC;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_DECODE: begin
        case (cls)
          CLS_BRANCH: state_d = ST_BRANCH;
          CLS_JUMP:   state_d = ST_JUMP;
          CLS_JR:     state_d = ST_JR;
          CLS_EXEC:   state_d = ST_EXEC;
          default:    state_d = ST_EXC;
        endcase
      end
      ST_BRANCH: begin
        pc_write = br_taken;
        pc_sel   = PCSRC_ALUOUT;
        state_d  = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_sel   = PCSRC_JUMP;
        // jal still owes the link-register write
        state_d  = (opcode == OP_JAL) ? ST_EXEC : ST_FETCH;
      end
      ST_JR: begin
        pc_write = 1'b1;
        pc_sel   = PCSRC_ALU;
        state_d  = ST_FETCH;
      end
      ST_EXEC: begin
        if (alu_ovf)        state_d = ST_EXC;
        else if (exec_done) state_d = ST_FETCH;
      end
      ST_EXC: begin
        epc_write = 1'b1;
        pc_write  = 1'b1;
        pc_sel    = PCSRC_EXC;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    // no strobe may leak out while reset is held
    if (!reset_n) begin
      fetch_req = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      epc_write = 1'b0;
    end
  end

  assign pc_source = pc_write ? PCSRC_W'(pc_sel) : '0;
endmodule
